fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address to instruction memory. Captures the returned instruction word, paired with its PC, into a small fetch queue.
- Presents queued instructions to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump), fetch halt, and misaligned-target traps.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 68 ++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push and
// discards everything left after a same-cycle pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             head_c_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_c_o,
  output logic                     empty_c_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_c_o = (cnt_q == '0);
  assign full_c_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o   = cnt_q;
  assign head_c_o  = empty_c_o ? '0 : mem_q[rd_q];

  assign do_pop  = pop_i && !empty_c_o;
  assign do_push = push_i && (!full_c_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset: the head reads zero whenever empty.
  always_ff @(posedge clk) begin
    if (rst && do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fills the fetch queue from imem and
// handles redirects, halt and misaligned-target traps.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        trap,
  output logic [31:0] trap_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
  logic             trap_q, trap_d;
  logic             push_c, pop_c, flush_c;
  logic             full_c, empty_c;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head_c;

  assign pop_c = !empty_c && out_ready;

  // Next-state, PC and trap logic; redirect outranks fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    push_c    = 1'b0;
    flush_c   = 1'b0;
    case (state_q)
      HOLD: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          flush_c = 1'b1;
          if (redirect_target[1:0] == 2'b00) begin
            pc_d = redirect_target;
          end else begin
            state_d   = TRAP;
            trap_d    = 1'b1;
            trap_pc_d = redirect_target;
          end
        end else if (!halt_req && (!full_c || pop_c)) begin
          push_c = 1'b1;
          pc_d   = pc_q + XLEN'(INSTR_BYTES);
        end
      end
      TRAP: state_d = TRAP;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HOLD;
      pc_q      <= RESET_PC;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH(FIFO_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_c),
    .pop_i    (pop_c),
    .flush_i  (flush_c),
    .wdata_i  ({pc_q, imem_instr}),
    .head_c_o (head_c),
    .count_o  (count),
    .full_c_o (full_c),
    .empty_c_o(empty_c)
  );

  // Address is forced to the reset vector while reset is asserted.
  assign imem_addr = rst ? pc_q : RESET_PC;
  assign out_valid = (count != '0);
  assign out_instr = head_c.instr;
  assign out_pc    = head_c.pc;
  assign trap      = trap_q;
  assign trap_pc   = trap_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH   = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam int S_HOLD = 0;
  localparam int S_RUN  = 1;
  localparam int S_TRAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_instr, redirect_target, out_instr, out_pc, trap_pc;
  logic        redirect_valid, halt_req, out_valid, out_ready, trap;
  logic [31:0] imem_addr1, imem_instr1, out_instr1, out_pc1, trap_pc1;
  logic        out_valid1, trap1;
  logic [31:0] seed;

  int tests = 0;
  int fails = 0;

  fetch_entry_t m_q[$];
  logic [31:0]  m_pc, m_trap_pc;
  logic         m_trap;
  int           m_state;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a, input logic [31:0] s);
    if (a == 32'h8) return 32'h0;
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign imem_instr  = imem(imem_addr, seed);
  assign imem_instr1 = imem(imem_addr1, seed);

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .trap(trap), .trap_pc(trap_pc)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(imem_addr1), .imem_instr(imem_instr1),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .out_valid(out_valid1), .out_ready(out_ready),
    .out_instr(out_instr1), .out_pc(out_pc1), .trap(trap1), .trap_pc(trap_pc1)
  );

  // Reference model for dut: one call per rising edge with the sampled inputs.
  function automatic void model_edge();
    logic pop;
    if (!rst) begin
      m_pc = 32'h0; m_q.delete(); m_state = S_HOLD; m_trap = 1'b0; m_trap_pc = 32'h0;
      return;
    end
    pop = (m_q.size() != 0) && out_ready;
    case (m_state)
      S_HOLD: m_state = S_RUN;
      S_RUN: begin
        if (redirect_valid) begin
          m_q.delete();
          if (redirect_target[1:0] == 2'b00) m_pc = redirect_target;
          else begin
            m_state = S_TRAP; m_trap = 1'b1; m_trap_pc = redirect_target;
          end
        end else begin
          if (pop) void'(m_q.pop_front());
          if (!halt_req && m_q.size() < int'(DEPTH)) begin
            m_q.push_back('{pc: m_pc, instr: imem(m_pc, seed)});
            m_pc = m_pc + 32'd4;
          end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [129:0] exp_view();
    fetch_entry_t h = '0;
    logic v = (m_q.size() != 0);
    if (v) h = m_q[0];
    return {v, h.pc, h.instr, (rst ? m_pc : 32'h0), m_trap, m_trap_pc};
  endfunction

  function automatic logic [129:0] dut_view();
    return {out_valid, out_pc, out_instr, imem_addr, trap, trap_pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0; out_ready = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b1; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin redirect_valid = 1'b1; redirect_target = 32'h102; end
      tick();
      tests++;
      if (dut_view() !== exp_view()) begin
        fails++; $display("FAIL reset_view cyc%0d: got %h want %h", k, dut_view(), exp_view());
      end
    end
    tests++;
    if (imem_addr !== 32'h0 || out_valid !== 1'b0 || trap !== 1'b0 || out_pc !== 32'h0 ||
        imem_addr1 !== WRAP_PC) begin
      fails++;
      $display("FAIL reset_const: addr=%h valid=%b trap=%b pc=%h addr1=%h want 0 0 0 0 %h",
               imem_addr, out_valid, trap, out_pc, imem_addr1, WRAP_PC);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_stream();
    reset_dut();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (dut_view() !== exp_view()) begin
        fails++; $display("FAIL stream_view cyc%0d: got %h want %h", k, dut_view(), exp_view());
      end
      if (k >= 2) begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'((k - 2) * 4)) begin
          fails++;
          $display("FAIL stream_pc cyc%0d: got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc,
                   32'((k - 2) * 4));
        end
      end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    out_ready = 1'b0;
    repeat (4) begin
      tick();
      tests++;
      if (dut_view() !== exp_view()) begin
        fails++; $display("FAIL stall_view: got %h want %h", dut_view(), exp_view());
      end
    end
    tests++;
    if (imem_addr !== 32'h8) begin
      fails++; $display("FAIL stall_addr: got %h want %h", imem_addr, 32'h8);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(k * 4)) begin
        fails++;
        $display("FAIL stall_drain k%0d: got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc,
                 32'(k * 4));
      end
      tick();
      tests++;
      if (dut_view() !== exp_view()) begin
        fails++; $display("FAIL stall_view2: got %h want %h", dut_view(), exp_view());
      end
    end
  endtask

  task automatic test_redirect_flush();
    bit found = 1'b0;
    reset_dut();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (out_valid === 1'b1 && out_pc === 32'h10) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL redir_reach: got pc=%h want %h", out_pc, 32'h10);
    end
    out_ready = 1'b0;
    tick();
    tests++;
    if (out_pc !== 32'h10 || imem_addr !== 32'h18 || dut_view() !== exp_view()) begin
      fails++; $display("FAIL redir_fill: got %h want %h", dut_view(), exp_view());
    end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h100 || dut_view() !== exp_view()) begin
      fails++; $display("FAIL redir_flush: got %h want %h", dut_view(), exp_view());
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || dut_view() !== exp_view()) begin
      fails++; $display("FAIL redir_target: got %h want %h", dut_view(), exp_view());
    end
  endtask

  task automatic test_trap();
    reset_dut();
    out_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    tests++;
    if (trap !== 1'b1 || trap_pc !== 32'h102 || out_valid !== 1'b0 || dut_view() !== exp_view()) begin
      fails++; $display("FAIL trap_entry: got %h want %h", dut_view(), exp_view());
    end
    redirect_target = 32'h200;
    for (int k = 0; k < 3; k++) begin
      halt_req = (k == 1);
      tick();
      tests++;
      if (trap !== 1'b1 || trap_pc !== 32'h102 || out_valid !== 1'b0 ||
          imem_addr === 32'h200 || dut_view() !== exp_view()) begin
        fails++; $display("FAIL trap_hold k%0d: got %h want %h", k, dut_view(), exp_view());
      end
    end
    redirect_valid = 1'b0; halt_req = 1'b0; rst = 1'b0;
    tick();
    tests++;
    if (trap !== 1'b0 || trap_pc !== 32'h0 || dut_view() !== exp_view()) begin
      fails++; $display("FAIL trap_clear: got %h want %h", dut_view(), exp_view());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    reset_dut();
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (out_valid1 !== 1'b1 || out_pc1 !== exp_pc[k] ||
          out_instr1 !== imem(exp_pc[k], seed)) begin
        fails++;
        $display("FAIL wrap k%0d: got v=%b pc=%h instr=%h want pc=%h instr=%h", k, out_valid1,
                 out_pc1, out_instr1, exp_pc[k], imem(exp_pc[k], seed));
      end
    end
  endtask

  task automatic test_halt();
    reset_dut();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1; halt_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin redirect_valid = 1'b1; redirect_target = 32'h40; end
      tick();
      tests++;
      if (imem_addr !== ((k == 2) ? 32'h40 : 32'h10) || dut_view() !== exp_view()) begin
        fails++; $display("FAIL halt k%0d: got %h want %h", k, dut_view(), exp_view());
      end
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL halt_drain: got %b want 0", out_valid);
    end
    halt_req = 1'b0; redirect_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || dut_view() !== exp_view()) begin
      fails++; $display("FAIL halt_resume: got %h want %h", dut_view(), exp_view());
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      rst            = ($urandom_range(0, 39) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      halt_req       = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_target = $urandom();
      if ($urandom_range(0, 15) != 0) redirect_target[1:0] = 2'b00;
      tick();
      tests++;
      if (dut_view() !== exp_view()) begin
        fails++; $display("FAIL random cyc%0d: got %h want %h", k, dut_view(), exp_view());
      end
    end
  endtask

  initial begin
    seed = $urandom();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_trap();
    test_wrap();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
